// File: rtl/gb_pkg.sv
// gb_pkg: shared DMG definitions used by the OAM DMA engine.
//   dma_state_t  - DMA engine states
//   OAM_BASE     - first OAM byte on the CPU bus
//   OAM_DMA_LEN  - bytes copied per DMA transfer
//   DMA_REG_ADDR - CPU address of the DMA start/page register
package gb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        XFER  = 2'd2
    } dma_state_t;

    localparam logic [15:0] OAM_BASE     = 16'hFE00;
    localparam int          OAM_DMA_LEN  = 160;
    localparam logic [15:0] DMA_REG_ADDR = 16'hFF46;

endpackage

// File: rtl/oam_dma_if.sv
// oam_dma_if: register, source-SRAM and OAM-write signals of the OAM DMA engine.
//   reg_we/reg_wdata/reg_rdata - FF46 write strobe, written page, readback
//   src_addr/src_re/src_data   - source SRAM read port (data one clk after re)
//   oam_addr/oam_wdata/oam_we  - OAM write port
//   busy                       - transfer active, CPU limited to HRAM
// Modports: master = DMA engine, slave = surrounding system.
interface oam_dma_if;
    logic        reg_we;
    logic [7:0]  reg_wdata;
    logic [7:0]  reg_rdata;
    logic [15:0] src_addr;
    logic        src_re;
    logic [7:0]  src_data;
    logic [7:0]  oam_addr;
    logic [7:0]  oam_wdata;
    logic        oam_we;
    logic        busy;

    modport master (
        input  reg_we, reg_wdata, src_data,
        output reg_rdata, src_addr, src_re, oam_addr, oam_wdata, oam_we, busy
    );

    modport slave (
        output reg_we, reg_wdata, src_data,
        input  reg_rdata, src_addr, src_re, oam_addr, oam_wdata, oam_we, busy
    );
endinterface

// File: rtl/oam_dma.sv
// oam_dma: sprite-attribute DMA. A write to FF46 copies LEN bytes from page
// XX00.. into OAM, one byte every CYC_PER_BYTE clocks, after a one-byte setup.
// Ports: clk, rst_n (synchronous, active-low), bus (oam_dma_if.master).
// Build option OAM_DMA_ECHO_EN: fold source pages E0-FF onto C0-DF.
//
// state | meaning
// IDLE  | no transfer, busy low
// SETUP | CYC_PER_BYTE clocks of lead-in before the first byte
// XFER  | phase 0 reads source, phase 1 writes OAM, others idle
module oam_dma
    import gb_pkg::*;
#(
    parameter int LEN          = OAM_DMA_LEN,
    parameter int CYC_PER_BYTE = 4
) (
    input  logic      clk,
    input  logic      rst_n,
    oam_dma_if.master bus
);

    localparam int             PW       = $clog2(CYC_PER_BYTE);
    localparam logic [PW-1:0]  LAST_PH  = PW'(CYC_PER_BYTE - 1);
    localparam logic [PW-1:0]  WR_PH    = PW'(1);
    localparam logic [7:0]     LAST_IDX = 8'(LEN - 1);

    dma_state_t    state_q, state_d;
    logic [PW-1:0] phase_q, phase_d;
    logic [7:0]    idx_q, idx_d;
    logic [7:0]    page_q, page_d;
    logic [7:0]    rdata_q, rdata_d;
    logic [15:0]   src_addr_q, src_addr_d;
    logic          src_re_q, src_re_d;
    logic [7:0]    oam_addr_q, oam_addr_d;
    logic [7:0]    oam_wdata_q, oam_wdata_d;
    logic          oam_we_q, oam_we_d;
    logic          busy_q, busy_d;

    // Echo RAM E000-FDFF mirrors C000-DDFF: clearing address bit 13 folds it.
    function automatic logic [7:0] src_page(input logic [7:0] p);
`ifdef OAM_DMA_ECHO_EN
        return (p[7:5] == 3'b111) ? (p & 8'hDF) : p;
`else
        return p;
`endif
    endfunction

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        idx_d   = idx_q;
        page_d  = page_q;
        rdata_d = rdata_q;

        // A register write restarts from any state and overrides the
        // terminal-phase exit, so busy never drops on a back-to-back start.
        if (bus.reg_we) begin
            state_d = SETUP;
            phase_d = '0;
            idx_d   = '0;
            page_d  = bus.reg_wdata;
            rdata_d = bus.reg_wdata;
        end else begin
            case (state_q)
                IDLE: ;
                SETUP: begin
                    if (phase_q == LAST_PH) begin
                        state_d = XFER;
                        phase_d = '0;
                        idx_d   = '0;
                    end else begin
                        phase_d = phase_q + 1'b1;
                    end
                end
                XFER: begin
                    if (phase_q == LAST_PH) begin
                        phase_d = '0;
                        if (idx_q == LAST_IDX) state_d = IDLE;
                        else                   idx_d   = idx_q + 8'd1;
                    end else begin
                        phase_d = phase_q + 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        // Outputs are registered from the next-state view so each strobe is
        // aligned with the phase it belongs to; a restart suppresses them.
        src_re_d    = (state_d == XFER) && (phase_d == '0);
        src_addr_d  = src_re_d ? {src_page(page_d), idx_d} : src_addr_q;
        oam_we_d    = (state_d == XFER) && (phase_d == WR_PH);
        oam_addr_d  = oam_we_d ? idx_d : oam_addr_q;
        oam_wdata_d = oam_we_d ? bus.src_data : oam_wdata_q;
        busy_d      = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            phase_q     <= '0;
            idx_q       <= '0;
            page_q      <= '0;
            rdata_q     <= 8'hFF;
            src_addr_q  <= '0;
            src_re_q    <= 1'b0;
            oam_addr_q  <= '0;
            oam_wdata_q <= '0;
            oam_we_q    <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            idx_q       <= idx_d;
            page_q      <= page_d;
            rdata_q     <= rdata_d;
            src_addr_q  <= src_addr_d;
            src_re_q    <= src_re_d;
            oam_addr_q  <= oam_addr_d;
            oam_wdata_q <= oam_wdata_d;
            oam_we_q    <= oam_we_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.reg_rdata = rdata_q;
    assign bus.src_addr  = src_addr_q;
    assign bus.src_re    = src_re_q;
    assign bus.oam_addr  = oam_addr_q;
    assign bus.oam_wdata = oam_wdata_q;
    assign bus.oam_we    = oam_we_q;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_oam_dma.sv
// tb_oam_dma: randomized self-checking bench for oam_dma. A timeline model
// derives every expected strobe from the clock count since the last FF46 write.
module tb_oam_dma;
    import gb_pkg::*;

    localparam int LEN       = 160;
    localparam int CYC       = 4;
    localparam int XFER_CLKS = (LEN + 1) * CYC;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    oam_dma_if u_if ();

    oam_dma #(.LEN(LEN), .CYC_PER_BYTE(CYC)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (u_if)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] fold(input logic [7:0] p);
`ifdef OAM_DMA_ECHO_EN
        if (p >= 8'hE0) return p - 8'h20;
`endif
        return p;
    endfunction

    // Source SRAM: byte n of any page reads n^5A; garbage when not selected.
    initial begin
        u_if.src_data = 8'h00;
        forever begin
            @(negedge clk);
            u_if.src_data = u_if.src_re ? (u_if.src_addr[7:0] ^ 8'h5A) : 8'($urandom);
        end
    end

    // Model: transfer timeline anchored at the edge that sampled the last write.
    int         cyc      = 0;
    logic       m_active = 1'b0;
    int         m_t0     = 0;
    logic [7:0] m_page   = 8'h00;
    logic [7:0] m_rdata  = 8'hFF;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst_n) begin
            m_active <= 1'b0;
            m_rdata  <= 8'hFF;
        end else if (u_if.reg_we) begin
            m_active <= 1'b1;
            m_t0     <= cyc + 1;
            m_page   <= u_if.reg_wdata;
            m_rdata  <= u_if.reg_wdata;
        end else if (m_active && (cyc + 1 - m_t0) >= XFER_CLKS) begin
            m_active <= 1'b0;
        end
    end

    int          n_busy = 0;
    int          n_we   = 0;
    logic [15:0] src_log[$];

    task automatic check_cycle();
        int   k;
        int   i;
        logic e_re;
        logic e_we;
        k    = cyc - m_t0;
        i    = k / CYC - 1;
        e_re = m_active && k >= CYC && (k % CYC) == 0;
        e_we = m_active && k >= CYC + 1 && (k % CYC) == 1;
        chk("busy", 32'(u_if.busy), 32'(m_active));
        chk("src_re", 32'(u_if.src_re), 32'(e_re));
        chk("oam_we", 32'(u_if.oam_we), 32'(e_we));
        chk("reg_rdata", 32'(u_if.reg_rdata), 32'(m_rdata));
        if (e_re) chk("src_addr", 32'(u_if.src_addr), {16'h0, fold(m_page), 8'(i)});
        if (e_we) begin
            chk("oam_addr", 32'(u_if.oam_addr), 32'(i));
            chk("oam_wdata", 32'(u_if.oam_wdata), 32'(8'(i) ^ 8'h5A));
        end
        if (u_if.busy) n_busy++;
        if (u_if.oam_we) n_we++;
        if (u_if.src_re) src_log.push_back(u_if.src_addr);
    endtask

    always @(negedge clk) check_cycle();

    task automatic write_reg(input logic [7:0] v);
        u_if.reg_we    = 1'b1;
        u_if.reg_wdata = v;
        @(negedge clk);
        u_if.reg_we    = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (u_if.busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("idle_timeout", 32'(u_if.busy), 32'd0);
    endtask

    int         b0, w0, s0, rb;
    logic [7:0] p, q;

    initial begin
        u_if.reg_we    = 1'b0;
        u_if.reg_wdata = 8'h00;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        chk("rst_src_addr", 32'(u_if.src_addr), 32'h0);
        chk("rst_oam_addr", 32'(u_if.oam_addr), 32'h0);
        chk("rst_oam_wdata", 32'(u_if.oam_wdata), 32'h0);

        // Quiet period
        b0 = n_busy; w0 = n_we; s0 = src_log.size();
        repeat (1000) @(negedge clk);
        chk("idle_busy_clks", 32'(n_busy - b0), 32'd0);
        chk("idle_we_cnt", 32'(n_we - w0), 32'd0);
        chk("idle_re_cnt", 32'(src_log.size() - s0), 32'd0);
        chk("idle_rdata", 32'(u_if.reg_rdata), 32'hFF);

        // Full transfer from C1
        b0 = n_busy; w0 = n_we; s0 = src_log.size();
        write_reg(8'hC1);
        wait_idle(700);
        chk("c1_busy_clks", 32'(n_busy - b0), 32'(XFER_CLKS));
        chk("c1_we_cnt", 32'(n_we - w0), 32'(LEN));
        chk("c1_re_cnt", 32'(src_log.size() - s0), 32'(LEN));
        chk("c1_first_src", 32'(src_log[s0]), 32'hC100);
        chk("c1_last_src", 32'(src_log[s0 + LEN - 1]), 32'hC19F);

        // Restart with D0 at byte 50
        b0 = n_busy; w0 = n_we; s0 = src_log.size();
        write_reg(8'hC1);
        repeat (CYC * 51 - 1) @(negedge clk);
        write_reg(8'hD0);
        wait_idle(900);
        chk("rs_busy_clks", 32'(n_busy - b0), 32'(CYC * 51 + XFER_CLKS));
        chk("rs_we_cnt", 32'(n_we - w0), 32'(50 + LEN));
        chk("rs_old_last", 32'(src_log[s0 + 49]), 32'hC131);
        chk("rs_new_first", 32'(src_log[s0 + 50]), 32'hD000);

        // Echo page FE
        s0 = src_log.size();
        write_reg(8'hFE);
        chk("fe_rdata", 32'(u_if.reg_rdata), 32'hFE);
        wait_idle(700);
`ifdef OAM_DMA_ECHO_EN
        chk("fe_first_src", 32'(src_log[s0]), 32'hDE00);
        chk("fe_last_src", 32'(src_log[s0 + LEN - 1]), 32'hDE9F);
`else
        chk("fe_first_src", 32'(src_log[s0]), 32'hFE00);
        chk("fe_last_src", 32'(src_log[s0 + LEN - 1]), 32'hFE9F);
`endif

        // Reset at byte 80
        b0 = n_busy; w0 = n_we;
        write_reg(8'hC1);
        repeat (CYC * 81 - 1) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("rst_mid_busy", 32'(u_if.busy), 32'd0);
        chk("rst_mid_rdata", 32'(u_if.reg_rdata), 32'hFF);
        chk("rst_mid_busy_clks", 32'(n_busy - b0), 32'(CYC * 81));
        chk("rst_mid_we_cnt", 32'(n_we - w0), 32'd80);
        w0 = n_we; s0 = src_log.size();
        repeat (20) @(negedge clk);
        chk("rst_mid_quiet", 32'((n_we - w0) + (src_log.size() - s0)), 32'd0);
        b0 = n_busy; w0 = n_we;
        write_reg(8'hC2);
        wait_idle(700);
        chk("c2_busy_clks", 32'(n_busy - b0), 32'(XFER_CLKS));
        chk("c2_we_cnt", 32'(n_we - w0), 32'(LEN));

        // Restart coinciding with the final phase
        b0 = n_busy; w0 = n_we; s0 = src_log.size();
        write_reg(8'hC1);
        repeat (XFER_CLKS - 1) @(negedge clk);
        write_reg(8'hC3);
        wait_idle(1400);
        chk("bb_busy_clks", 32'(n_busy - b0), 32'(2 * XFER_CLKS));
        chk("bb_we_cnt", 32'(n_we - w0), 32'(2 * LEN));
        chk("bb_second_first", 32'(src_log[s0 + LEN]), 32'hC300);

        // Random pages with random restart points
        for (int t = 0; t < 4; t++) begin
            p  = 8'($urandom);
            q  = 8'($urandom);
            rb = $urandom_range(1, LEN - 1);
            w0 = n_we; s0 = src_log.size();
            write_reg(p);
            repeat (CYC * (rb + 1) - 1) @(negedge clk);
            write_reg(q);
            wait_idle(1400);
            chk("rnd_we_cnt", 32'(n_we - w0), 32'(rb + LEN));
            chk("rnd_new_first", 32'(src_log[s0 + rb]), {16'h0, fold(q), 8'h00});
        end

        repeat (5) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
